// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM:
// states, opcodes, ALUOp codes and the decoded control bundle.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS: sequences each instruction
// through fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               illegal,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count,
  output logic [3:0]         state
);

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  ctrl_t               c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state_q)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_4;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM2;
        c.alu_op    = ALUOP_ADD;
        unique case (opcode)
          OP_RTYPE, OP_LW, OP_SW,
          OP_BEQ, OP_J, OP_ADDI: c.illegal = 1'b0;
          default:               c.illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.done      = mem_ready;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.done          = 1'b1;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
        c.done      = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      default: c = '0;
    endcase
  end

  // Strobes are squashed while reset is held so an abandoned
  // instruction cannot write anything.
  assign PCWrite     = c.pc_write      & reset_n;
  assign PCWriteCond = c.pc_write_cond & reset_n;
  assign MemRead     = c.mem_read      & reset_n;
  assign MemWrite    = c.mem_write     & reset_n;
  assign IRWrite     = c.ir_write      & reset_n;
  assign RegWrite    = c.reg_write     & reset_n;
  assign illegal     = c.illegal       & reset_n;
  assign instr_done  = c.done          & reset_n;
  assign IorD        = c.iord;
  assign MemtoReg    = c.mem_to_reg;
  assign RegDst      = c.reg_dst;
  assign ALUSrcA     = c.alu_src_a;
  assign ALUSrcB     = c.alu_src_b;
  assign ALUOp       = c.alu_op;
  assign PCSource    = c.pc_source;

  assign cnt_d       = instr_done ? cnt_q + COUNT_W'(1) : cnt_q;
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors
// push expectations, a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal, instr_done;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] instr_count;
  logic [3:0] state;

  multicycle_control #(.COUNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode),
    .mem_ready(mem_ready), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .illegal(illegal), .instr_done(instr_done),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [3:0]  cnt;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  string phase = "reset";
  int    vec = 0;
  int    bad = 0;
  int    mcnt = 0;

  // Expected outputs straight from the per-state output table.
  function automatic logic [16:0] spec_out(
    input logic [3:0] st, input logic mr,
    input logic [5:0] op, input logic rst);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  begin
        srcb = 2'b11;
        ill = !(op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08});
      end
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin srca = 1; aop = 2'b10; end
      4'd7:  begin rdst = 1; rw = 1; end
      4'd8:  begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      4'd9:  begin pcw = 1; psrc = 2'b10; end
      4'd10: begin srca = 1; srcb = 2'b10; end
      4'd11: begin rw = 1; end
      default: ;
    endcase
    if (!rst) {pcw, pcwc, mrd, mwr, irw, rw, ill} = '0;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
            srcb, aop, psrc, ill};
  endfunction

  task automatic cyc(input logic [5:0] op, input logic mr,
                     input logic rst, input logic [3:0] st,
                     input logic done);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; mem_ready = mr; reset_n = rst;
    e.st  = st;
    e.ctl = {spec_out(st, mr, op, rst), done};
    e.cnt = 4'(mcnt);
    q.push_back(e);
    tq.push_back(phase);
    if (!rst) mcnt = 0;
    else if (done) mcnt = (mcnt + 1) % 16;
  endtask

  always @(negedge clk) begin
    exp_t  e;
    exp_t  g;
    string t;
    if (q.size() > 0) begin
      e = q.pop_front();
      t = tq.pop_front();
      g.st  = state;
      g.ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal, instr_done};
      g.cnt = instr_count;
      vec++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s vec%0d: got st=%0d ctl=%b cnt=%0d, want st=%0d ctl=%b cnt=%0d",
                 t, vec, g.st, g.ctl, g.cnt, e.st, e.ctl, e.cnt);
      end
    end
  end

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b;
  localparam logic [5:0] BQ = 6'h04, J = 6'h02, AI = 6'h08;

  initial begin
    phase = "reset";
    repeat (3) cyc(R, 1, 0, 0, 0);

    phase = "rtype";
    repeat (3) begin
      cyc(R, 1, 1, 0, 0); cyc(R, 1, 1, 1, 0);
      cyc(R, 1, 1, 6, 0); cyc(R, 1, 1, 7, 1);
    end

    phase = "lw_wait";
    cyc(LW, 1, 1, 0, 0); cyc(LW, 1, 1, 1, 0); cyc(LW, 1, 1, 2, 0);
    cyc(LW, 0, 1, 3, 0); cyc(LW, 0, 1, 3, 0); cyc(LW, 1, 1, 3, 0);
    cyc(LW, 0, 1, 4, 1);

    phase = "sw";
    cyc(SW, 1, 1, 0, 0); cyc(SW, 1, 1, 1, 0); cyc(SW, 1, 1, 2, 0);
    cyc(SW, 1, 1, 5, 1);

    phase = "beq_fwait";
    cyc(BQ, 0, 1, 0, 0); cyc(BQ, 1, 1, 0, 0); cyc(BQ, 1, 1, 1, 0);
    cyc(BQ, 1, 1, 8, 1);

    phase = "j";
    cyc(J, 1, 1, 0, 0); cyc(J, 1, 1, 1, 0); cyc(J, 1, 1, 9, 1);

    phase = "sw_wait";
    cyc(SW, 1, 1, 0, 0); cyc(SW, 1, 1, 1, 0); cyc(SW, 1, 1, 2, 0);
    cyc(SW, 0, 1, 5, 0); cyc(SW, 1, 1, 5, 1);

    phase = "addi";
    cyc(AI, 1, 1, 0, 0); cyc(AI, 1, 1, 1, 0); cyc(AI, 1, 1, 10, 0);
    cyc(AI, 1, 1, 11, 1);

    phase = "illegal";
    cyc(6'h3f, 1, 1, 0, 0); cyc(6'h3f, 1, 1, 1, 0);
    cyc(R, 1, 1, 0, 0); cyc(R, 1, 1, 1, 0);
    cyc(R, 1, 1, 6, 0); cyc(R, 1, 1, 7, 1);

    phase = "reset_mid_lw";
    cyc(LW, 1, 1, 0, 0); cyc(LW, 1, 1, 1, 0); cyc(LW, 1, 1, 2, 0);
    cyc(LW, 0, 1, 3, 0); cyc(LW, 1, 0, 3, 0); cyc(LW, 1, 1, 0, 0);
    cyc(LW, 1, 1, 1, 0); cyc(LW, 1, 1, 2, 0); cyc(LW, 1, 1, 3, 0);
    cyc(LW, 1, 1, 4, 1);

    phase = "reset2";
    cyc(J, 1, 0, 0, 0);

    phase = "j_wrap";
    repeat (16) begin
      cyc(J, 1, 1, 0, 0); cyc(J, 1, 1, 1, 0); cyc(J, 1, 1, 9, 1);
    end
    cyc(R, 0, 1, 0, 0);
    cyc(R, 0, 1, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
